// File: rtl/conv_layer_ctrl_if.sv
// Signal bundle linking conv_layer_ctrl to the layer top, conv_blk and its
// weight / feature-map / result BRAMs.
interface conv_layer_ctrl_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 28,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1,
  parameter int MAXPOOL     = 0,
  parameter int OUT_FM_CH   = 4,
  parameter int NUM_PE      = 1,
  parameter int B_W         = 18,
  parameter int DW          = 48
);
  localparam int KW        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int OUT_SIZE  = ((FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE) + 1;
  localparam int OUT_WORDS = (MAXPOOL != 0) ? (OUT_SIZE / 2) * (OUT_SIZE / 2) : OUT_SIZE * OUT_SIZE;
  localparam int FM_WORDS  = FM_SIZE * FM_SIZE;
  localparam int PW        = (OUT_FM_CH > 1) ? $clog2(OUT_FM_CH) : 1;
  localparam int WAW       = (OUT_FM_CH * KW > 1) ? $clog2(OUT_FM_CH * KW) : 1;
  localparam int FAW       = (FM_WORDS > 1) ? $clog2(FM_WORDS) : 1;
  localparam int RAW       = (OUT_FM_CH * OUT_WORDS > 1) ? $clog2(OUT_FM_CH * OUT_WORDS) : 1;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [PW-1:0]        pass;
  logic                 w_rd;
  logic [WAW-1:0]       w_addr;
  logic [B_W-1:0]       w_data;
  logic                 blk_rst;
  logic                 weight_en;
  logic [B_W-1:0]       weight_data;
  logic                 fm_rd;
  logic [FAW-1:0]       fm_addr;
  logic                 go;
  logic                 blk_en;
  logic [DW*NUM_PE-1:0] blk_result;
  logic                 res_we;
  logic [RAW-1:0]       res_addr;
  logic [DW*NUM_PE-1:0] res_data;

  modport master (
    input  start, w_data, blk_en, blk_result,
    output busy, done, err, pass, w_rd, w_addr, blk_rst, weight_en, weight_data,
           fm_rd, fm_addr, go, res_we, res_addr, res_data
  );

  modport slave (
    output start, w_data, blk_en, blk_result,
    input  busy, done, err, pass, w_rd, w_addr, blk_rst, weight_en, weight_data,
           fm_rd, fm_addr, go, res_we, res_addr, res_data
  );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer: per output channel clears conv_blk, loads its weights,
// streams the feature map and collects results into the output BRAM.
module conv_layer_ctrl #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 28,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1,
  parameter int MAXPOOL     = 0,
  parameter int OUT_FM_CH   = 4,
  parameter int NUM_PE      = 1,
  parameter int B_W         = 18,
  parameter int DW          = 48,
  parameter int DRAIN_TMO   = 4096
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  conv_layer_ctrl_if.master bus
);
  localparam int KW         = KERNEL_SIZE * KERNEL_SIZE;
  localparam int OUT_SIZE   = ((FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE) + 1;
  localparam int OUT_WORDS  = (MAXPOOL != 0) ? (OUT_SIZE / 2) * (OUT_SIZE / 2) : OUT_SIZE * OUT_SIZE;
  localparam int FM_WORDS   = FM_SIZE * FM_SIZE;
  localparam int STREAM_LEN = (FM_SIZE + 2 * PADDING) * (FM_SIZE + 2 * PADDING);
  localparam int PW         = (OUT_FM_CH > 1) ? $clog2(OUT_FM_CH) : 1;
  localparam int WAW        = (OUT_FM_CH * KW > 1) ? $clog2(OUT_FM_CH * KW) : 1;
  localparam int FAW        = (FM_WORDS > 1) ? $clog2(FM_WORDS) : 1;
  localparam int RAW        = (OUT_FM_CH * OUT_WORDS > 1) ? $clog2(OUT_FM_CH * OUT_WORDS) : 1;
  localparam int CNT_MAX    = (STREAM_LEN > KW)
                              ? ((STREAM_LEN > DRAIN_TMO) ? STREAM_LEN : DRAIN_TMO)
                              : ((KW > DRAIN_TMO) ? KW : DRAIN_TMO);
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam int OCW        = $clog2(OUT_WORDS + 1);

  typedef enum logic [2:0] {IDLE, CLR, LOAD_W, STREAM, DRAIN, NEXT} state_t;

  state_t         state;
  logic           busy;
  logic           done;
  logic           err;
  logic           blk_rst;
  logic           w_rd;
  logic           weight_en;
  logic           fm_rd;
  logic           strobe;
  logic           go;
  logic [PW-1:0]  pass;
  logic [WAW-1:0] w_addr;
  logic [FAW-1:0] fm_addr;
  logic [CW-1:0]  cnt;
  logic [OCW-1:0] rcnt;
  logic           capture;

  // Results pass straight through to the output BRAM while a slot is still free.
  always_comb begin
    capture = ((state == STREAM) || (state == DRAIN)) && bus.blk_en && (rcnt != OCW'(OUT_WORDS));
  end

  // Layer sequencing FSM; o_go and o_weight_en trail their read strobes by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      blk_rst   <= 1'b1;
      w_rd      <= 1'b0;
      weight_en <= 1'b0;
      fm_rd     <= 1'b0;
      strobe    <= 1'b0;
      go        <= 1'b0;
      pass      <= {PW{1'b0}};
      w_addr    <= {WAW{1'b0}};
      fm_addr   <= {FAW{1'b0}};
      cnt       <= {CW{1'b0}};
      rcnt      <= {OCW{1'b0}};
    end else begin
      weight_en <= w_rd;
      go        <= strobe;
      if (capture) begin
        rcnt <= rcnt + OCW'(1);
      end
      case (state)
        IDLE: begin
          done    <= 1'b0;
          blk_rst <= 1'b1;
          if (bus.start && !done) begin
            state <= CLR;
            busy  <= 1'b1;
            err   <= 1'b0;
            pass  <= {PW{1'b0}};
            cnt   <= {CW{1'b0}};
          end
        end
        CLR: begin
          if (cnt == CW'(1)) begin
            state   <= LOAD_W;
            blk_rst <= 1'b0;
            w_rd    <= 1'b1;
            w_addr  <= WAW'(pass) * WAW'(KW);
            cnt     <= {CW{1'b0}};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD_W: begin
          if (w_rd) begin
            if (cnt == CW'(KW - 1)) begin
              w_rd <= 1'b0;
            end else begin
              w_addr <= w_addr + WAW'(1);
              cnt    <= cnt + CW'(1);
            end
          end else begin
            // Last weight enable is on the bus now; go starts only after it.
            state   <= STREAM;
            strobe  <= 1'b1;
            fm_rd   <= 1'b1;
            fm_addr <= {FAW{1'b0}};
            cnt     <= {CW{1'b0}};
          end
        end
        STREAM: begin
          if (strobe) begin
            if (cnt == CW'(STREAM_LEN - 1)) begin
              strobe <= 1'b0;
              fm_rd  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
              if (cnt < CW'(FM_WORDS - 1)) begin
                fm_rd   <= 1'b1;
                fm_addr <= FAW'(cnt + CW'(1));
              end else begin
                fm_rd <= 1'b0;
              end
            end
          end else begin
            state <= DRAIN;
            cnt   <= {CW{1'b0}};
          end
        end
        DRAIN: begin
          if (rcnt == OCW'(OUT_WORDS)) begin
            state <= NEXT;
          end else if (cnt == CW'(DRAIN_TMO - 1)) begin
            state <= NEXT;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        NEXT: begin
          rcnt    <= {OCW{1'b0}};
          cnt     <= {CW{1'b0}};
          blk_rst <= 1'b1;
          if (pass < PW'(OUT_FM_CH - 1)) begin
            pass  <= pass + PW'(1);
            state <= CLR;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.err         = err;
  assign bus.pass        = pass;
  assign bus.w_rd        = w_rd;
  assign bus.w_addr      = w_addr;
  assign bus.blk_rst     = blk_rst;
  assign bus.weight_en   = weight_en;
  assign bus.weight_data = weight_en ? bus.w_data : {B_W{1'b0}};
  assign bus.fm_rd       = fm_rd;
  assign bus.fm_addr     = fm_addr;
  assign bus.go          = go;
  assign bus.res_we      = capture;
  assign bus.res_addr    = capture ? (RAW'(pass) * RAW'(OUT_WORDS) + RAW'(rcnt)) : {RAW{1'b0}};
  assign bus.res_data    = capture ? bus.blk_result : {(DW*NUM_PE){1'b0}};
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: BRAM model, randomized conv_blk stubs and a
// reference built from per-pass address/count formulas.
module tb_conv_layer_ctrl;
  localparam int K = 3, FM = 4, NP = 2, KW = 9, FW = 16, TMO = 50;
  localparam int OW0 = 4, SL0 = 16, OW1 = 16, SL1 = 36;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_layer_ctrl_if #(.KERNEL_SIZE(K), .FM_SIZE(FM), .PADDING(0), .OUT_FM_CH(NP)) bus0 ();
  conv_layer_ctrl_if #(.KERNEL_SIZE(K), .FM_SIZE(FM), .PADDING(1), .OUT_FM_CH(NP)) bus1 ();

  conv_layer_ctrl #(.KERNEL_SIZE(K), .FM_SIZE(FM), .PADDING(0), .OUT_FM_CH(NP), .DRAIN_TMO(TMO))
    dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0.master));
  conv_layer_ctrl #(.KERNEL_SIZE(K), .FM_SIZE(FM), .PADDING(1), .OUT_FM_CH(NP), .DRAIN_TMO(TMO))
    dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1.master));

  int n_tests = 0, n_fail = 0;
  logic [17:0] w_mem [0:NP*KW-1];
  int n_emit = 4, max_gap = 3;

  int wrd_q[$], fm_q[$], seg_q[$], ra_q[$], emit_t[$];
  logic [63:0] wen_q[$], rd_q[$], emit_d[$];
  int fm1_q[$], seg1_q[$], ra1_q[$];
  int n_done = 0, n_overlap = 0, n_done1 = 0;
  int go_len = 0, go_len1 = 0;
  logic prev_wrd = 1'b0;

  int rem0 = 0, gap0 = 0, gr_cnt = 0, cur_tag = 0, rem1 = 0;
  logic go0_d = 1'b0, go1_d = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Weight BRAM with one cycle read latency, shared by both instances
  always @(posedge clk) begin
    if (bus0.w_rd) bus0.w_data <= w_mem[bus0.w_addr];
    if (bus1.w_rd) bus1.w_data <= w_mem[bus1.w_addr];
  end

  // conv_blk stub for dut0: n_emit results with random gaps once go starts
  always @(posedge clk) begin
    go0_d <= bus0.go;
    if (!rst_n) begin
      rem0 <= 0; gap0 <= 0; gr_cnt <= 0;
      bus0.blk_en <= 1'b0; bus0.blk_result <= 48'h0;
    end else if (bus0.go && !go0_d) begin
      rem0 <= n_emit; gap0 <= int'($urandom_range(3, 1));
      cur_tag <= gr_cnt % NP; gr_cnt <= gr_cnt + 1;
      bus0.blk_en <= 1'b0;
    end else if (rem0 > 0 && gap0 == 0) begin
      bus0.blk_en <= 1'b1; bus0.blk_result <= 48'({$urandom(), $urandom()});
      rem0 <= rem0 - 1; gap0 <= int'($urandom_range(max_gap, 0));
    end else begin
      bus0.blk_en <= 1'b0;
      if (gap0 > 0) gap0 <= gap0 - 1;
    end
  end

  // conv_blk stub for dut1: OW1 back-to-back results per pass
  always @(posedge clk) begin
    go1_d <= bus1.go;
    if (!rst_n) begin
      rem1 <= 0; bus1.blk_en <= 1'b0; bus1.blk_result <= 48'h0;
    end else if (bus1.go && !go1_d) begin
      rem1 <= OW1; bus1.blk_en <= 1'b0;
    end else if (rem1 > 0) begin
      rem1 <= rem1 - 1; bus1.blk_en <= 1'b1; bus1.blk_result <= 48'({$urandom(), $urandom()});
    end else begin
      bus1.blk_en <= 1'b0;
    end
  end

  // Mid-cycle monitors logging bus activity
  always @(negedge clk) begin
    prev_wrd <= bus0.w_rd;
    if (bus0.weight_en || prev_wrd) chk("wen_align", bus0.weight_en, prev_wrd);
    if (bus0.w_rd) wrd_q.push_back(int'(bus0.w_addr));
    if (bus0.weight_en) wen_q.push_back(64'(bus0.weight_data));
    if (bus0.fm_rd) fm_q.push_back(int'(bus0.fm_addr));
    if (bus0.go && bus0.weight_en) n_overlap++;
    if (bus0.go) go_len <= go_len + 1;
    else if (go_len != 0) begin seg_q.push_back(go_len); go_len <= 0; end
    if (bus0.res_we) begin ra_q.push_back(int'(bus0.res_addr)); rd_q.push_back(64'(bus0.res_data)); end
    if (bus0.blk_en) begin emit_d.push_back(64'(bus0.blk_result)); emit_t.push_back(cur_tag); end
    if (bus0.done) n_done++;
    if (bus1.fm_rd) fm1_q.push_back(int'(bus1.fm_addr));
    if (bus1.go) go_len1 <= go_len1 + 1;
    else if (go_len1 != 0) begin seg1_q.push_back(go_len1); go_len1 <= 0; end
    if (bus1.res_we) ra1_q.push_back(int'(bus1.res_addr));
    if (bus1.done) n_done1++;
  end

  task automatic clear_logs();
    wrd_q.delete(); fm_q.delete(); seg_q.delete(); ra_q.delete(); emit_t.delete();
    wen_q.delete(); rd_q.delete(); emit_d.delete();
    fm1_q.delete(); seg1_q.delete(); ra1_q.delete();
    n_done = 0; n_overlap = 0; n_done1 = 0;
  endtask

  task automatic fill_w(input bit ramp);
    for (int i = 0; i < NP*KW; i++) w_mem[i] = ramp ? 18'(100 + i) : 18'($urandom());
  endtask

  task automatic start_run();
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    chk("busy_after_start", bus0.busy, 1);
    chk("err_cleared", bus0.err, 0);
    chk("pass_start", bus0.pass, 0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus0.done) begin ok = 1'b1; break; end
    end
    chk("done_seen", ok, 1);
    chk("busy_at_done", bus0.busy, 0);
  endtask

  task automatic wait_pass1(input bit need_go, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus0.pass == 1'b1 && (!need_go || bus0.go)) begin ok = 1'b1; break; end
    end
    chk("reach_pass1", ok, 1);
  endtask

  // Expected bus traffic of one complete layer on dut0
  task automatic check_run(input bit exp_err, input int exp_writes);
    int k;
    int ea[$];
    logic [63:0] ed[$];
    chk("w_rd_count", wrd_q.size(), NP*KW);
    foreach (wrd_q[i]) chk("w_addr", wrd_q[i], i);
    chk("w_en_count", wen_q.size(), NP*KW);
    foreach (wen_q[i]) if (i < NP*KW) chk("w_data", wen_q[i], 64'(w_mem[i]));
    chk("go_segments", seg_q.size(), NP);
    foreach (seg_q[i]) chk("go_len", seg_q[i], SL0);
    chk("fm_rd_count", fm_q.size(), NP*FW);
    foreach (fm_q[i]) chk("fm_addr", fm_q[i], i % FW);
    for (int p = 0; p < NP; p++) begin
      k = 0;
      foreach (emit_t[e]) if (emit_t[e] == p && k < OW0) begin
        ea.push_back(p*OW0 + k); ed.push_back(emit_d[e]); k++;
      end
    end
    chk("res_count", ra_q.size(), exp_writes);
    foreach (ra_q[i]) if (i < ea.size()) begin
      chk("res_addr", ra_q[i], ea[i]);
      chk("res_data", rd_q[i], ed[i]);
    end
    chk("done_pulses", n_done, 1);
    chk("go_wen_overlap", n_overlap, 0);
    chk("err_final", bus0.err, exp_err);
  endtask

  initial begin
    bit ok;
    bus0.start = 1'b0; bus1.start = 1'b0;
    fill_w(1'b1);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus0.busy, 0);     chk("rst_done", bus0.done, 0);
    chk("rst_err", bus0.err, 0);       chk("rst_blk_rst", bus0.blk_rst, 1);
    chk("rst_pass", bus0.pass, 0);     chk("rst_w_rd", bus0.w_rd, 0);
    chk("rst_wen", bus0.weight_en, 0); chk("rst_go", bus0.go, 0);
    chk("rst_fm_rd", bus0.fm_rd, 0);   chk("rst_res_we", bus0.res_we, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_blk_rst", bus0.blk_rst, 1);

    // Run A: ramp weights, normal results, padded instance in parallel
    clear_logs(); n_emit = 4; max_gap = 3;
    @(negedge clk); bus0.start = 1'b1; bus1.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0; bus1.start = 1'b0;
    chk("busy_after_start", bus0.busy, 1);
    chk("busy1_after_start", bus1.busy, 1);
    wait_done(ok);
    @(negedge clk);
    check_run(1'b0, NP*OW0);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin @(negedge clk); ok = (n_done1 != 0); end
    chk("pad_done_seen", ok, 1);
    chk("pad_go_segments", seg1_q.size(), NP);
    foreach (seg1_q[i]) chk("pad_go_len", seg1_q[i], SL1);
    chk("pad_fm_rd_count", fm1_q.size(), NP*FW);
    foreach (fm1_q[i]) chk("pad_fm_addr", fm1_q[i], i % FW);
    chk("pad_res_count", ra1_q.size(), NP*OW1);
    foreach (ra1_q[i]) chk("pad_res_addr", ra1_q[i], i);
    chk("pad_err", bus1.err, 0);
    chk("pad_done_pulses", n_done1, 1);

    // Run B: surplus results, restart attempts mid-run and on the done cycle
    clear_logs(); fill_w(1'b0); n_emit = 6; max_gap = 1;
    start_run();
    wait_pass1(1'b0, ok);
    bus0.start = 1'b1; @(negedge clk); bus0.start = 1'b0;
    chk("midrun_busy", bus0.busy, 1);
    chk("midrun_pass", bus0.pass, 1);
    wait_done(ok);
    bus0.start = 1'b1; @(negedge clk); bus0.start = 1'b0;
    chk("start_at_done_ignored", bus0.busy, 0);
    check_run(1'b0, NP*OW0);

    // Run C: only 3 of 4 results per pass, drain timeout
    clear_logs(); fill_w(1'b0); n_emit = 3; max_gap = 3;
    start_run();
    wait_pass1(1'b0, ok);
    chk("err_after_tmo", bus0.err, 1);
    chk("busy_after_tmo", bus0.busy, 1);
    wait_done(ok);
    @(negedge clk);
    check_run(1'b1, NP*3);

    // Run D: reset during pass 1 streaming
    clear_logs(); fill_w(1'b0); n_emit = 4; max_gap = 3;
    start_run();
    wait_pass1(1'b1, ok);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus0.busy, 0);       chk("abort_blk_rst", bus0.blk_rst, 1);
    chk("abort_go", bus0.go, 0);           chk("abort_fm_rd", bus0.fm_rd, 0);
    chk("abort_pass", bus0.pass, 0);       chk("abort_res_we", bus0.res_we, 0);
    chk("abort_wen", bus0.weight_en, 0);   chk("abort_w_rd", bus0.w_rd, 0);
    chk("abort_res_data", bus0.res_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", n_done, 0);

    // Run E: fresh layer after the abort
    clear_logs(); fill_w(1'b0); n_emit = 4; max_gap = 3;
    start_run();
    wait_done(ok);
    @(negedge clk);
    check_run(1'b0, NP*OW0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
Sequencer that runs one full convolution layer on a single conv_blk instance, one output channel (pass) at a time. Each pass goes through four steps: clear the block, load that channel's KERNEL_SIZE² weights from weight BRAM, stream the feature map from FM BRAM with i_go, then collect o_en results into the output BRAM. It sits between the layer-level top (start/done) and conv_blk plus its three BRAMs.

Parameters:
KERNEL_SIZE, 3, kernel side; weights per pass KW = KERNEL_SIZE²
FM_SIZE, 28, input FM side (unpadded)
PADDING, 0, zero padding per side
STRIDE, 1, conv stride
MAXPOOL, 0, 1 = 2x2 maxpool enabled in conv_blk
OUT_FM_CH, 4, number of passes NP
NUM_PE, 1, PE lanes (sets FM/result bus widths)
A_W, 18, FM lane width (`A_DSP_WIDTH)
B_W, 18, weight width (`B_DSP_WIDTH)
DW, 48, result lane width (`DW)
DRAIN_TMO, 4096, max cycles in DRAIN before error

Derived: OUT_SIZE=((FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE)+1; OUT_WORDS = MAXPOOL ? (OUT_SIZE/2)² : OUT_SIZE²; STREAM_LEN=(FM_SIZE+2*PADDING)²; FM_WORDS=FM_SIZE². Address widths are $clog2 of the respective depths, minimum 1.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous, active-low reset
i_start  in  1  start-layer pulse; ignored while o_busy
o_busy  out  1  high from the cycle after accepted start until DONE
o_done  out  1  one-cycle pulse on layer completion
o_err  out  1  sticky drain-timeout flag; cleared by the next accepted start
o_pass  out  clog2(NP)  current output channel
o_w_rd, o_w_addr  out  1, clog2(NP*KW)  weight BRAM read; 1-cycle latency
i_w_data  in  B_W  weight BRAM data
o_blk_rst  out  1  conv_blk i_rst (active-high)
o_weight_en  out  1  conv_blk i_weight_en
o_weight_data  out  B_W  conv_blk i_weight_data
o_fm_rd, o_fm_addr  out  1, clog2(FM_WORDS)  FM BRAM read; 1-cycle latency
o_go  out  1  conv_blk i_go
i_blk_en  in  1  conv_blk o_en
i_blk_result  in  DW*NUM_PE  conv_blk o_conv_result
o_res_we, o_res_addr, o_res_data  out  1, clog2(NP*OUT_WORDS), DW*NUM_PE  output BRAM write

Behaviour:
- Reset (async assert, sync release): state IDLE, pass=0, all counters 0. All outputs 0 except o_blk_rst=1. A reset mid-pass aborts immediately; no o_done pulse.
- FSM states: IDLE, CLR, LOAD_W, STREAM, DRAIN, NEXT.
- IDLE: o_blk_rst=1. i_start → CLR, o_busy=1, o_err cleared, pass=0.
- CLR: o_blk_rst=1 for exactly 2 cycles, then → LOAD_W with o_blk_rst=0.
- LOAD_W: o_w_rd=1 with o_w_addr=pass*KW+j for j=0..KW-1 on consecutive cycles. One cycle later: o_weight_en=1, o_weight_data=i_w_data. Exactly KW enables, contiguous. After the last enable → STREAM. o_go stays 0 throughout LOAD_W (weight_en has priority in conv_blk).
- STREAM: issue o_fm_rd with o_fm_addr=0..FM_WORDS-1. o_go is the read strobe delayed by 1 cycle and is held high for exactly STREAM_LEN cycles.
  - PADDING>0: reads are issued on the first FM_WORDS of those cycles; during the rest, o_go stays high and o_fm_rd=0.
  - After the last o_go cycle → DRAIN.
- Result capture (STREAM, DRAIN): each i_blk_en=1 cycle gives o_res_we=1, o_res_data=i_blk_result, o_res_addr=pass*OUT_WORDS+rcnt, then rcnt++.
  - Zero added latency (combinational pass-through, registered next cycle is not allowed).
  - Once rcnt==OUT_WORDS, further i_blk_en is ignored (no write).
  - i_blk_en outside STREAM/DRAIN is ignored.
- DRAIN: rcnt==OUT_WORDS → NEXT. A cycle counter reaching DRAIN_TMO also → NEXT, and sets o_err=1.
- NEXT (1 cycle): rcnt=0.
  - pass<NP-1: pass++ → CLR.
  - Otherwise: o_done=1, o_busy=0 → IDLE.
- i_start while busy: no effect. i_start in the same cycle as o_done: ignored; it must be re-asserted.

Test Plan:
- K=3, FM=4, P=0, MAXPOOL=0, NP=2 → per pass: 9 weight_en carrying weight addrs 0..8 then 9..17, 16 o_go cycles, 4 result writes at res addrs 0..3 then 4..7, a single o_done, o_busy low afterwards.
- Weight timing: BRAM model returns addr+100 → o_weight_data sequence 100..108 aligned with o_weight_en, exactly one cycle after each o_w_rd.
- P=1, FM=4 → 36 o_go cycles per pass, exactly 16 o_fm_rd, fm addrs 0..15.
- conv_blk stub emits only 3 of 4 results, DRAIN_TMO=50 → o_err=1 at the timeout, pass advances, o_done still pulses.
- Extra i_blk_en after 4 results and a 2nd i_start mid-run → no extra writes, no restart.
- i_rst_n low during STREAM of pass 1 → all outputs 0 immediately, o_blk_rst=1; a fresh start then runs cleanly from pass 0.
